// File: rtl/control_sequencer.sv
// control_sequencer -- microcode sequencer for a small bus-based CPU.
//
// A step counter (T_STATE) walks T0..T4 and every bus/register control is a
// purely combinational decode of the current step, the sticky HALTED flag,
// the opcode and the ALU flags. Instructions are variable length: the counter
// wraps to T0 right after the last useful step of each opcode.
//
// Ports
//   CLOCK, CLEAR_n          rising-edge clock, async active-low reset
//   IR_DATA                 opcode (upper bits beyond [3:0] must be zero)
//   ZERO_FLAG, CARRY_FLAG   registered ALU flags, used by JZ / JC
//   *_n outputs             active-low bus/register controls
//   PC_COUNT_ENABLE, OUT_READ_BUS, ALU_SUBTRACT, CLOCK_HALT  active-high
//   T_STATE                 current microstep
//   HALTED                  sticky halt, cleared only by CLEAR_n
//   ILLEGAL                 undefined opcode seen in T2
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    CLOCK,
  input  logic                    CLEAR_n,
  input  logic [OPCODE_WIDTH-1:0] IR_DATA,
  input  logic                    ZERO_FLAG,
  input  logic                    CARRY_FLAG,
  output logic                    PC_COUNT_ENABLE,
  output logic                    OUT_READ_BUS,
  output logic                    ALU_SUBTRACT,
  output logic                    CLOCK_HALT,
  output logic                    PC_JUMP_n,
  output logic                    PC_WRITE_BUS_n,
  output logic                    MAR_READ_BUS_n,
  output logic                    RAM_READ_BUS_n,
  output logic                    RAM_WRITE_BUS_n,
  output logic                    A_READ_BUS_n,
  output logic                    A_WRITE_BUS_n,
  output logic                    B_READ_BUS_n,
  output logic                    IR_READ_BUS_n,
  output logic                    IR_WRITE_BUS_n,
  output logic                    ALU_WRITE_BUS_n,
  output logic                    FLAGS_UPDATE_n,
  output logic [STEP_WIDTH-1:0]   T_STATE,
  output logic                    HALTED,
  output logic                    ILLEGAL
);

  localparam logic [STEP_WIDTH-1:0] S0 = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] S1 = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] S2 = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] S3 = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] S4 = STEP_WIDTH'(4);

  localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_ADD = 4'h2,
                         OP_SUB = 4'h3, OP_STA = 4'h4, OP_LDI = 4'h5,
                         OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                         OP_OUT = 4'hE, OP_HLT = 4'hF;

  logic [STEP_WIDTH-1:0] t_q, t_d;
  logic                  halted_q, halted_d;
  logic                  hi_nz;     // opcode has bits set above [3:0]
  logic [3:0]            op;
  logic                  op_undef;  // illegal: high bits or 0x9..0xD
  logic [STEP_WIDTH-1:0] last_step;

  // A 4-bit opcode has no high field to check.
  generate
    if (OPCODE_WIDTH > 4) begin : g_hi
      assign hi_nz = |IR_DATA[OPCODE_WIDTH-1:4];
    end else begin : g_nohi
      assign hi_nz = 1'b0;
    end
  endgenerate

  // Illegal opcodes are folded onto 0x9 so they decode exactly like a NOP.
  assign op       = hi_nz ? 4'h9 : IR_DATA[3:0];
  assign op_undef = (op >= 4'h9) && (op <= 4'hD);

  always_comb begin
    last_step = S2;
    if (op == OP_LDA || op == OP_STA) last_step = S3;
    if (op == OP_ADD || op == OP_SUB) last_step = S4;
  end

  always_comb begin
    t_d      = t_q;
    halted_d = halted_q;
    if (t_q > S4) begin
      t_d = S0;                           // unreachable encodings recover
    end else if (!halted_q) begin
      if (t_q == S2 && op == OP_HLT) halted_d = 1'b1;  // freeze at T2
      else if (t_q >= last_step)      t_d = S0;
      else                            t_d = t_q + S1;
    end
  end

  always_ff @(posedge CLOCK or negedge CLEAR_n) begin
    if (!CLEAR_n) begin
      t_q      <= S0;
      halted_q <= 1'b0;
    end else begin
      t_q      <= t_d;
      halted_q <= halted_d;
    end
  end

  assign T_STATE = t_q;
  assign HALTED  = halted_q;

  // Control decode. Gated by CLEAR_n so T0 controls stay quiet in reset.
  always_comb begin
    PC_COUNT_ENABLE = 1'b0;
    OUT_READ_BUS    = 1'b0;
    ALU_SUBTRACT    = 1'b0;
    CLOCK_HALT      = 1'b0;
    PC_JUMP_n       = 1'b1;
    PC_WRITE_BUS_n  = 1'b1;
    MAR_READ_BUS_n  = 1'b1;
    RAM_READ_BUS_n  = 1'b1;
    RAM_WRITE_BUS_n = 1'b1;
    A_READ_BUS_n    = 1'b1;
    A_WRITE_BUS_n   = 1'b1;
    B_READ_BUS_n    = 1'b1;
    IR_READ_BUS_n   = 1'b1;
    IR_WRITE_BUS_n  = 1'b1;
    ALU_WRITE_BUS_n = 1'b1;
    FLAGS_UPDATE_n  = 1'b1;
    ILLEGAL         = 1'b0;
    if (CLEAR_n) begin
      if (halted_q) begin
        CLOCK_HALT = 1'b1;
      end else if (t_q == S0) begin
        PC_WRITE_BUS_n = 1'b0;
        MAR_READ_BUS_n = 1'b0;
      end else if (t_q == S1) begin
        RAM_WRITE_BUS_n = 1'b0;
        IR_READ_BUS_n   = 1'b0;
        PC_COUNT_ENABLE = 1'b1;
      end else if (t_q == S2) begin
        ILLEGAL = op_undef;
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            IR_WRITE_BUS_n = 1'b0;
            MAR_READ_BUS_n = 1'b0;
          end
          OP_LDI: begin
            IR_WRITE_BUS_n = 1'b0;
            A_READ_BUS_n   = 1'b0;
          end
          OP_JMP: begin
            IR_WRITE_BUS_n = 1'b0;
            PC_JUMP_n      = 1'b0;
          end
          OP_JC: begin
            IR_WRITE_BUS_n = !CARRY_FLAG;
            PC_JUMP_n      = !CARRY_FLAG;
          end
          OP_JZ: begin
            IR_WRITE_BUS_n = !ZERO_FLAG;
            PC_JUMP_n      = !ZERO_FLAG;
          end
          OP_OUT: begin
            A_WRITE_BUS_n = 1'b0;
            OUT_READ_BUS  = 1'b1;
          end
          OP_HLT:  CLOCK_HALT = 1'b1;
          default: ;                      // NOP and illegal
        endcase
      end else if (t_q == S3) begin
        case (op)
          OP_LDA: begin
            RAM_WRITE_BUS_n = 1'b0;
            A_READ_BUS_n    = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            RAM_WRITE_BUS_n = 1'b0;
            B_READ_BUS_n    = 1'b0;
            ALU_SUBTRACT    = (op == OP_SUB);
          end
          OP_STA: begin
            A_WRITE_BUS_n  = 1'b0;
            RAM_READ_BUS_n = 1'b0;
          end
          default: ;
        endcase
      end else if (t_q == S4) begin
        if (op == OP_ADD || op == OP_SUB) begin
          ALU_WRITE_BUS_n = 1'b0;
          A_READ_BUS_n    = 1'b0;
          FLAGS_UPDATE_n  = 1'b0;
          ALU_SUBTRACT    = (op == OP_SUB);
        end
      end
    end
  end

  logic unused_nop;
  assign unused_nop = (OP_NOP == 4'h0);

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized scoreboard bench for control_sequencer (OPCODE_WIDTH=6 so the
// illegal high-bit opcodes are reachable). The stimulus process drives one
// cycle at a time, asks a table-driven instruction model what the outputs
// should be and queues that; a separate monitor pops and compares.
module tb_control_sequencer;

  logic       CLOCK = 1'b0;
  logic       CLEAR_n = 1'b0;
  logic [5:0] IR_DATA = '0;
  logic       ZERO_FLAG = 1'b0, CARRY_FLAG = 1'b0;
  logic PC_COUNT_ENABLE, OUT_READ_BUS, ALU_SUBTRACT, CLOCK_HALT;
  logic PC_JUMP_n, PC_WRITE_BUS_n, MAR_READ_BUS_n, RAM_READ_BUS_n;
  logic RAM_WRITE_BUS_n, A_READ_BUS_n, A_WRITE_BUS_n, B_READ_BUS_n;
  logic IR_READ_BUS_n, IR_WRITE_BUS_n, ALU_WRITE_BUS_n, FLAGS_UPDATE_n;
  logic [2:0] T_STATE;
  logic HALTED, ILLEGAL;

  control_sequencer #(.OPCODE_WIDTH(6), .STEP_WIDTH(3)) dut (
    .CLOCK(CLOCK), .CLEAR_n(CLEAR_n), .IR_DATA(IR_DATA),
    .ZERO_FLAG(ZERO_FLAG), .CARRY_FLAG(CARRY_FLAG),
    .PC_COUNT_ENABLE(PC_COUNT_ENABLE), .OUT_READ_BUS(OUT_READ_BUS),
    .ALU_SUBTRACT(ALU_SUBTRACT), .CLOCK_HALT(CLOCK_HALT),
    .PC_JUMP_n(PC_JUMP_n), .PC_WRITE_BUS_n(PC_WRITE_BUS_n),
    .MAR_READ_BUS_n(MAR_READ_BUS_n), .RAM_READ_BUS_n(RAM_READ_BUS_n),
    .RAM_WRITE_BUS_n(RAM_WRITE_BUS_n), .A_READ_BUS_n(A_READ_BUS_n),
    .A_WRITE_BUS_n(A_WRITE_BUS_n), .B_READ_BUS_n(B_READ_BUS_n),
    .IR_READ_BUS_n(IR_READ_BUS_n), .IR_WRITE_BUS_n(IR_WRITE_BUS_n),
    .ALU_WRITE_BUS_n(ALU_WRITE_BUS_n), .FLAGS_UPDATE_n(FLAGS_UPDATE_n),
    .T_STATE(T_STATE), .HALTED(HALTED), .ILLEGAL(ILLEGAL)
  );

  always #5 CLOCK = ~CLOCK;

  // Control bit positions in the "asserted" vector (polarity removed).
  localparam logic [15:0] PCE = 16'h0001, OUT = 16'h0002, SUB = 16'h0004,
    HLTC = 16'h0008, JMP = 16'h0010, PCW = 16'h0020, MARR = 16'h0040,
    RAMR = 16'h0080, RAMW = 16'h0100, AR = 16'h0200, AW = 16'h0400,
    BR = 16'h0800, IRR = 16'h1000, IRW = 16'h2000, ALUW = 16'h4000,
    FLG = 16'h8000;

  typedef struct { logic [20:0] exp; int cyc; } item_t;
  item_t exp_q[$];
  int n_checks = 0, n_pass = 0, cyc_no = 0;

  // Reference model state: position within the current instruction.
  int m_step = 0;
  bit m_halt = 0;

  function automatic int ilen(input logic [5:0] ir);
    if (ir > 6'd15) return 3;
    case (ir[3:0])
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [20:0] model_out(input logic [5:0] ir,
                                            input bit c, z, rst);
    logic [15:0] a = '0;
    bit ill = 0;
    if (!rst) return '0;
    if (m_halt) return {3'(m_step), 1'b1, 1'b0, HLTC};
    if (m_step == 0) a = PCW | MARR;
    else if (m_step == 1) a = RAMW | IRR | PCE;
    else if (ir > 6'd15) ill = (m_step == 2);
    else case (ir[3:0])
      4'h1: a = (m_step == 2) ? (IRW | MARR) : (RAMW | AR);
      4'h2, 4'h3: begin
        if (m_step == 2) a = IRW | MARR;
        else if (m_step == 3) a = RAMW | BR;
        else a = ALUW | AR | FLG;
        if (ir[3:0] == 4'h3 && m_step > 2) a = a | SUB;
      end
      4'h4: a = (m_step == 2) ? (IRW | MARR) : (AW | RAMR);
      4'h5: a = IRW | AR;
      4'h6: a = IRW | JMP;
      4'h7: a = c ? (IRW | JMP) : 16'h0;
      4'h8: a = z ? (IRW | JMP) : 16'h0;
      4'hE: a = AW | OUT;
      4'hF: a = HLTC;
      4'h0: a = '0;
      default: ill = (m_step == 2);
    endcase
    return {3'(m_step), 1'b0, ill, a};
  endfunction

  function automatic void model_edge(input logic [5:0] ir);
    if (m_halt) return;
    if (m_step == 2 && ir == 6'h0F) m_halt = 1;
    else m_step = (m_step + 1 == ilen(ir)) ? 0 : m_step + 1;
  endfunction

  task automatic push_exp(input logic [5:0] ir, input bit c, z, rst);
    item_t it;
    it.exp = model_out(ir, c, z, rst);
    it.cyc = cyc_no;
    exp_q.push_back(it);
  endtask

  // One clock: inputs change at the falling edge, model steps at the rise.
  task automatic cyc(input logic [5:0] ir, input bit c, z, rst);
    @(negedge CLOCK);
    cyc_no++;
    IR_DATA = ir; CARRY_FLAG = c; ZERO_FLAG = z; CLEAR_n = rst;
    if (!rst) begin m_step = 0; m_halt = 0; end
    #1 push_exp(ir, c, z, rst);
    @(posedge CLOCK);
    if (rst) model_edge(ir);
  endtask

  task automatic run_instr(input logic [5:0] ir, input bit c, z, rnd);
    int n = 0;
    do begin
      if (rnd) cyc(ir, 1'($urandom), 1'($urandom), 1'b1);
      else     cyc(ir, c, z, 1'b1);
      n++;
    end while (m_step != 0 && !m_halt && n < 8);
  endtask

  // Monitor: every queued expectation is compared 1 ns after it appears.
  initial begin
    item_t it;
    logic [20:0] act;
    forever begin
      wait (exp_q.size() > 0);
      #1;
      it = exp_q.pop_front();
      act = {T_STATE, HALTED, ILLEGAL,
             ~FLAGS_UPDATE_n, ~ALU_WRITE_BUS_n, ~IR_WRITE_BUS_n,
             ~IR_READ_BUS_n, ~B_READ_BUS_n, ~A_WRITE_BUS_n, ~A_READ_BUS_n,
             ~RAM_WRITE_BUS_n, ~RAM_READ_BUS_n, ~MAR_READ_BUS_n,
             ~PC_WRITE_BUS_n, ~PC_JUMP_n, CLOCK_HALT, ALU_SUBTRACT,
             OUT_READ_BUS, PC_COUNT_ENABLE};
      n_checks++;
      if (act === it.exp) n_pass++;
      else $display("FAIL outputs cycle %0d: got T=%0d H=%b I=%b ctl=%h, want T=%0d H=%b I=%b ctl=%h",
                    it.cyc, act[20:18], act[17], act[16], act[15:0],
                    it.exp[20:18], it.exp[17], it.exp[16], it.exp[15:0]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] ir;
    // Reset state: everything quiet, T0 controls held off.
    cyc(6'h0, 0, 0, 0);
    cyc(6'h0, 1, 1, 0);
    // Directed instructions.
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h00, 0, 0, 0);
    run_instr(6'h02, 0, 0, 0);
    run_instr(6'h03, 0, 0, 0);
    run_instr(6'h07, 0, 0, 0);
    run_instr(6'h07, 1, 0, 0);
    run_instr(6'h08, 0, 0, 0);
    run_instr(6'h08, 0, 1, 0);
    run_instr(6'h11, 0, 0, 0);
    run_instr(6'h0A, 0, 0, 0);
    run_instr(6'h05, 0, 0, 0);
    run_instr(6'h06, 0, 0, 0);
    run_instr(6'h0E, 0, 0, 0);
    run_instr(6'h04, 0, 0, 0);
    // LDA interrupted asynchronously in T3, mid low phase.
    repeat (3) cyc(6'h01, 0, 0, 1);
    @(negedge CLOCK);
    cyc_no++;
    #1 push_exp(6'h01, 0, 0, 1);
    #2 CLEAR_n = 1'b0; m_step = 0; m_halt = 0;
    push_exp(6'h01, 0, 0, 0);
    @(posedge CLOCK);
    run_instr(6'h01, 0, 0, 0);
    // Halt: frozen for 20 cycles regardless of inputs, then cleared.
    run_instr(6'h0F, 0, 0, 0);
    repeat (20) cyc(6'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    cyc(6'h0F, 0, 0, 0);
    run_instr(6'h00, 0, 0, 0);
    // Random programs with occasional halts and mid-instruction resets.
    repeat (150) begin
      ir = 6'($urandom_range(0, 15));
      if (ir == 6'h0F && $urandom_range(0, 2) != 0) ir = 6'h00;
      if ($urandom_range(0, 7) == 0) ir[5:4] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(1, 3)) cyc(ir, 1'($urandom), 1'($urandom), 1'b1);
        cyc(ir, 1'($urandom), 1'($urandom), 1'b0);
      end else begin
        run_instr(ir, 0, 0, 1);
      end
      if (m_halt) begin
        repeat ($urandom_range(1, 5)) cyc(6'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        cyc(6'h00, 0, 0, 0);
      end
    end
    @(negedge CLOCK);
    #4;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter OPCODE_WIDTH, default 4: width of IR_DATA; SHALL be >= 4.
REQ-002 Parameter STEP_WIDTH, default 3: width of T_STATE; SHALL be large enough to encode steps T0..T4.
REQ-003 CLOCK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 CLEAR_n  in  1  asynchronous, active-low reset.
REQ-005 IR_DATA  in  OPCODE_WIDTH  opcode from the instruction register.
REQ-006 ZERO_FLAG, CARRY_FLAG  in  1 each  registered ALU flags.
REQ-007 PC_COUNT_ENABLE, OUT_READ_BUS, ALU_SUBTRACT, CLOCK_HALT  out  1 each  active-high controls.
REQ-008 PC_JUMP_n, PC_WRITE_BUS_n, MAR_READ_BUS_n, RAM_READ_BUS_n, RAM_WRITE_BUS_n, A_READ_BUS_n, A_WRITE_BUS_n, B_READ_BUS_n, IR_READ_BUS_n, IR_WRITE_BUS_n, ALU_WRITE_BUS_n, FLAGS_UPDATE_n  out  1 each  active-low controls.
REQ-009 T_STATE  out  STEP_WIDTH  current microstep; HALTED  out  1  sticky halt; ILLEGAL  out  1  undefined opcode in execute.

Function
REQ-010 Unlisted controls SHALL be inactive in every step (active-low = 1, active-high = 0).
REQ-011 Controls SHALL be a combinational decode of T_STATE, the HALTED flag, IR_DATA and the flags only; no other state.
REQ-012 T0 (fetch address): PC_WRITE_BUS_n=0, MAR_READ_BUS_n=0.
REQ-013 T1 (fetch opcode): RAM_WRITE_BUS_n=0, IR_READ_BUS_n=0, PC_COUNT_ENABLE=1.
REQ-014 T2 onward SHALL decode IR_DATA[3:0] when IR_DATA[OPCODE_WIDTH-1:4] is all zero; any other value SHALL be treated as illegal.
REQ-015 NOP 0x0: T2 asserts nothing.
REQ-016 LDA 0x1: T2 IR_WRITE_BUS_n=0 and MAR_READ_BUS_n=0; T3 RAM_WRITE_BUS_n=0 and A_READ_BUS_n=0.
REQ-017 ADD 0x2: T2 as LDA; T3 RAM_WRITE_BUS_n=0 and B_READ_BUS_n=0; T4 ALU_WRITE_BUS_n=0, A_READ_BUS_n=0, FLAGS_UPDATE_n=0.
REQ-018 SUB 0x3: same as ADD, with ALU_SUBTRACT=1 in T3 and T4.
REQ-019 STA 0x4: T2 as LDA; T3 A_WRITE_BUS_n=0 and RAM_READ_BUS_n=0.
REQ-020 LDI 0x5: T2 IR_WRITE_BUS_n=0 and A_READ_BUS_n=0.
REQ-021 JMP 0x6: T2 IR_WRITE_BUS_n=0 and PC_JUMP_n=0.
REQ-022 JC 0x7 / JZ 0x8: T2 SHALL behave as JMP when CARRY_FLAG / ZERO_FLAG is 1, and as NOP otherwise.
REQ-023 OUT 0xE: T2 A_WRITE_BUS_n=0 and OUT_READ_BUS=1.
REQ-024 HLT 0xF: T2 CLOCK_HALT=1; the next edge SHALL set HALTED.
REQ-025 Opcodes 0x9-0xD and illegal opcodes SHALL execute as NOP, with ILLEGAL=1 during T2.
REQ-026 Instruction length is variable: T_STATE SHALL return to 0 on the edge after the last step, with no padding steps.
- 3 steps: NOP, LDI, JMP, JC, JZ, OUT, illegal.
- 4 steps: LDA, STA.
- 5 steps: ADD, SUB.
REQ-027 While HALTED=1:
- T_STATE SHALL freeze.
- CLOCK_HALT SHALL remain 1.
- All other controls SHALL be inactive.
- Only CLEAR_n SHALL exit this state.
REQ-028 A flag change in the same cycle as JC/JZ T2 SHALL use the flag value present in that cycle.
REQ-029 T_STATE SHALL never exceed 4; any unreachable encoding SHALL return to 0 on the next edge.

Reset
REQ-030 CLEAR_n=0 SHALL immediately, without a clock edge, force T_STATE=0, HALTED=0, ILLEGAL=0, and all controls inactive, including CLOCK_HALT=0.
REQ-031 Reset mid-instruction, in any step or while halted, SHALL abandon the instruction; execution SHALL restart with T0 decode on the first edge after CLEAR_n rises.
REQ-032 During reset, T0 controls SHALL NOT be asserted; they SHALL appear combinationally once CLEAR_n=1.

Verification
REQ-033 Reset release, IR_DATA=0x0: T_STATE sequence 0,1,2,0,1,...; PC_WRITE_BUS_n=0 only in T0; PC_COUNT_ENABLE=1 only in T1.
REQ-034 IR_DATA=0x2 then 0x3: 5-step cycles; ALU_WRITE_BUS_n=0 and FLAGS_UPDATE_n=0 only in T4; ALU_SUBTRACT=1 in T3 and T4 only for 0x3.
REQ-035 IR_DATA=0x7: CARRY_FLAG=0 gives PC_JUMP_n=1 in T2; CARRY_FLAG=1 gives PC_JUMP_n=0 in T2; likewise 0x8 with ZERO_FLAG.
REQ-036 IR_DATA=0xF: CLOCK_HALT=1 from T2; HALTED=1 after the next edge; T_STATE frozen at 2 for 20 cycles; CLEAR_n pulse gives T_STATE=0, HALTED=0.
REQ-037 OPCODE_WIDTH=6, IR_DATA=0x11: ILLEGAL=1 in T2, no other execute controls, return to T0 after 3 steps.
REQ-038 CLEAR_n asserted asynchronously in T3 of LDA: outputs inactive and T_STATE=0 before the next edge; normal fetch after release.
